perf_sampler: RTL and testbench

Wishbone initiator that periodically sweeps the four performance-counter registers at 0x99000000–0x9900000C with single classic read cycles. It optionally clears each counter after reading it by writing to the same address, and streams each snapshot out on a valid/ready sample port. It sits as an extra master on the system bus, next to the counter slave, and feeds a logger or UART dumper.

---
 rtl/perf_sampler.sv | 210 +++++++++++++++++++++
 tb/tb_perf_sampler.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_sampler.sv
// perf_sampler: Wishbone initiator that periodically sweeps NUM_CTR
// performance counters with single classic read cycles, optionally clears
// each counter after reading it, and streams every snapshot out on a
// valid/ready sample port.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   enable            run periodic sweeps
//   period            idle cycles between sweeps (WAIT lasts period+1 cycles)
//   clear_on_read     write 0 to each counter after a successful read
//   wb_*              Wishbone classic initiator port
//   smp_valid/ready   sample handshake; smp_idx/data/err/last are the payload
//   busy              high outside IDLE and WAIT
//   err_cnt           aborted bus cycles, saturating at 255
module perf_sampler #(
    parameter logic [31:0] BASE_ADR = 32'h9900_0000,
    parameter int unsigned NUM_CTR  = 4,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clear_on_read,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [31:0]         wb_adr_o,
    output logic [3:0]          wb_sel_o,
    output logic [31:0]         wb_dat_o,
    input  logic [31:0]         wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic                wb_rty_i,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic [1:0]          smp_idx,
    output logic [31:0]         smp_data,
    output logic                smp_err,
    output logic                smp_last,
    output logic                busy,
    output logic [7:0]          err_cnt
);

    localparam int unsigned WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [1:0]  LAST_IDX = 2'(NUM_CTR - 1);
    localparam logic [7:0]  ERR_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD,
        S_CLR,
        S_PUSH
    } state_t;

    state_t              state;
    logic [1:0]          idx;
    logic [PERIOD_W-1:0] timer;
    logic [WD_W-1:0]     watchdog;

    logic       bus_err_c;
    logic       wd_expired_c;
    logic [7:0] err_cnt_inc_c;

    // Retry is treated exactly like an error.
    assign bus_err_c     = wb_err_i | wb_rty_i;
    // Watchdog holds 0..TIMEOUT while strobing; reaching TIMEOUT aborts.
    assign wd_expired_c  = (watchdog == WD_W'(TIMEOUT));
    assign err_cnt_inc_c = (err_cnt == ERR_MAX) ? ERR_MAX : err_cnt + 8'd1;

    // Clears only ever write zero.
    assign wb_dat_o = 32'd0;

    function automatic logic [31:0] ctr_adr(input logic [1:0] i);
        return BASE_ADR + {28'd0, i, 2'b00};
    endfunction

    // Sweep sequencer with registered bus and sample outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            timer     <= '0;
            watchdog  <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= 32'd0;
            wb_sel_o  <= 4'h0;
            smp_valid <= 1'b0;
            smp_idx   <= 2'd0;
            smp_data  <= 32'd0;
            smp_err   <= 1'b0;
            smp_last  <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_WAIT;
                        timer <= period;
                    end
                end

                S_WAIT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (timer == '0) begin
                        state    <= S_RD;
                        idx      <= 2'd0;
                        busy     <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= 4'hF;
                        wb_adr_o <= ctr_adr(2'd0);
                        watchdog <= '0;
                    end else begin
                        timer <= timer - PERIOD_W'(1);
                    end
                end

                S_RD: begin
                    smp_idx  <= idx;
                    smp_last <= (idx == LAST_IDX);
                    // Priority: err/rty over ack over watchdog expiry.
                    if (bus_err_c || (wd_expired_c && !wb_ack_i)) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_sel_o  <= 4'h0;
                        wb_adr_o  <= 32'd0;
                        smp_data  <= 32'd0;
                        smp_err   <= 1'b1;
                        err_cnt   <= err_cnt_inc_c;
                        smp_valid <= 1'b1;
                        state     <= S_PUSH;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                        wb_adr_o <= 32'd0;
                        smp_data <= wb_dat_i;
                        smp_err  <= 1'b0;
                        if (clear_on_read) begin
                            state <= S_CLR;
                        end else begin
                            smp_valid <= 1'b1;
                            state     <= S_PUSH;
                        end
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end

                S_CLR: begin
                    // First CLR cycle is the idle gap after the read; the
                    // write cycle starts from there.
                    if (!wb_cyc_o) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b1;
                        wb_sel_o <= 4'hF;
                        wb_adr_o <= ctr_adr(idx);
                        watchdog <= '0;
                    end else if (bus_err_c || wb_ack_i || wd_expired_c) begin
                        if (bus_err_c || !wb_ack_i) begin
                            err_cnt <= err_cnt_inc_c;
                            smp_err <= 1'b1;
                        end
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= 4'h0;
                        wb_adr_o  <= 32'd0;
                        smp_valid <= 1'b1;
                        state     <= S_PUSH;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end

                S_PUSH: begin
                    if (smp_ready) begin
                        smp_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= S_WAIT;
                            timer <= period;
                            busy  <= 1'b0;
                        end else begin
                            idx      <= idx + 2'd1;
                            state    <= S_RD;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b0;
                            wb_sel_o <= 4'hF;
                            wb_adr_o <= ctr_adr(idx + 2'd1);
                            watchdog <= '0;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_sampler.sv
// Bench for perf_sampler: a registered 1-cycle-ack counter slave, a queue
// model of the expected bus transfers and samples, and one negedge compare
// process checking the bus protocol and sample stream every cycle.
module tb_perf_sampler;

    localparam int unsigned TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] period = 16'd0;
    logic        clear_on_read = 1'b0;
    logic        smp_ready = 1'b1;

    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;
    logic        smp_valid, smp_err, smp_last, busy;
    logic [1:0]  smp_idx;
    logic [31:0] smp_data;
    logic [7:0]  err_cnt;

    perf_sampler #(
        .BASE_ADR(32'h9900_0000),
        .NUM_CTR (4),
        .PERIOD_W(16),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .period       (period),
        .clear_on_read(clear_on_read),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_adr_o     (wb_adr_o),
        .wb_sel_o     (wb_sel_o),
        .wb_dat_o     (wb_dat_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_rty_i     (wb_rty_i),
        .smp_valid    (smp_valid),
        .smp_ready    (smp_ready),
        .smp_idx      (smp_idx),
        .smp_data     (smp_data),
        .smp_err      (smp_err),
        .smp_last     (smp_last),
        .busy         (busy),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;
    int exp_err = 0;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- counter slave: registered ack one cycle after stb
    logic [31:0] mem [4];
    logic [31:0] load_val [4];
    logic        load_req = 1'b0;
    int          err_idx  = -1;
    int          hang_idx = -1;

    always @(posedge clk) begin
        wb_ack_i <= 1'b0;
        wb_err_i <= 1'b0;
        wb_rty_i <= 1'b0;
        if (load_req)
            for (int k = 0; k < 4; k++) mem[k] <= load_val[k];
        if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
            if (!wb_we_o && int'(wb_adr_o[3:2]) == err_idx) begin
                wb_err_i <= 1'b1;
            end else if (!(!wb_we_o && int'(wb_adr_o[3:2]) == hang_idx)) begin
                wb_ack_i <= 1'b1;
                if (wb_we_o) mem[wb_adr_o[3:2]] <= wb_dat_o;
                else         wb_dat_i <= mem[wb_adr_o[3:2]];
            end
        end
    end

    // ---------------- expectation model
    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
        logic        err;
    } smp_t;
    typedef struct {
        logic [31:0] adr;
        logic        we;
    } txn_t;

    smp_t exp_q[$];
    txn_t txn_q[$];
    int   starts[$];
    int   hs[$];
    int   lens[$];

    // One sweep: a read per counter, a clear write after each good read when
    // clearing, and a sample per counter; counter 'bad' fails its read.
    task automatic exp_sweep(input logic [31:0] d0, d1, d2, d3, input int bad, input logic clr);
        logic [31:0] d[4];
        smp_t s;
        txn_t t;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < 4; i++) begin
            t.adr = 32'h9900_0000 + 32'(4 * i);
            t.we  = 1'b0;
            txn_q.push_back(t);
            if (clr && i != bad) begin
                t.we = 1'b1;
                txn_q.push_back(t);
            end
            s.idx  = 2'(i);
            s.data = (i == bad) ? 32'd0 : d[i];
            s.err  = (i == bad);
            exp_q.push_back(s);
            if (i == bad) exp_err++;
        end
    endtask

    // ---------------- per-cycle compare process
    logic        p_stb = 1'b0, p_term = 1'b0, p_valid = 1'b0, p_ready = 1'b0;
    logic        p_err = 1'b0, p_last = 1'b0;
    logic [1:0]  p_idx = 2'd0;
    logic [31:0] p_adr = 32'd0, p_data = 32'd0;
    int          stb_len = 0;
    smp_t        ce;
    txn_t        ct;

    always @(negedge clk) begin
        if (!rst) begin
            p_stb = 1'b0; p_term = 1'b0; p_valid = 1'b0; p_ready = 1'b0;
            stb_len = 0;
        end else begin
            if (wb_cyc_o) begin
                check("sel_during_cycle", 32'(wb_sel_o), 32'hF);
                check("dat_o_zero", wb_dat_o, 32'd0);
                check("stb_with_cyc", 32'(wb_stb_o), 32'd1);
                check("busy_on_bus", 32'(busy), 32'd1);
            end
            if (p_stb && p_term)
                check("cyc_drop_after_term", 32'(wb_cyc_o), 32'd0);
            if (p_stb && wb_stb_o && !p_term)
                check("adr_stable", wb_adr_o, p_adr);
            if (wb_stb_o && !p_stb) begin
                starts.push_back(cyc_no);
                stb_len = 1;
                if (txn_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_txn: adr 0x%0h we %0b, none expected", wb_adr_o, wb_we_o);
                end else begin
                    ct = txn_q.pop_front();
                    check("txn_adr", wb_adr_o, ct.adr);
                    check("txn_we", 32'(wb_we_o), 32'(ct.we));
                end
            end else if (wb_stb_o) begin
                stb_len++;
            end
            if (!wb_stb_o && p_stb) lens.push_back(stb_len);
            if (p_valid && !p_ready) begin
                check("valid_held", 32'(smp_valid), 32'd1);
                check("idx_held", 32'(smp_idx), 32'(p_idx));
                check("data_held", smp_data, p_data);
                check("err_held", 32'(smp_err), 32'(p_err));
                check("last_held", 32'(smp_last), 32'(p_last));
            end
            if (smp_valid) begin
                check("bus_idle_in_push", 32'(wb_cyc_o), 32'd0);
                check("busy_in_push", 32'(busy), 32'd1);
            end
            if (smp_valid && smp_ready) begin
                hs.push_back(cyc_no);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_sample: idx %0d data 0x%0h, none expected", smp_idx, smp_data);
                end else begin
                    ce = exp_q.pop_front();
                    check("smp_idx", 32'(smp_idx), 32'(ce.idx));
                    check("smp_data", smp_data, ce.data);
                    check("smp_err", 32'(smp_err), 32'(ce.err));
                    check("smp_last", 32'(smp_last), 32'(ce.idx == 2'd3));
                end
            end
            p_stb   = wb_stb_o;
            p_term  = wb_ack_i | wb_err_i | wb_rty_i;
            p_adr   = wb_adr_o;
            p_valid = smp_valid;
            p_ready = smp_ready;
            p_idx   = smp_idx;
            p_data  = smp_data;
            p_err   = smp_err;
            p_last  = smp_last;
        end
    end

    // ---------------- helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, b, c, d);
        load_val[0] = a; load_val[1] = b; load_val[2] = c; load_val[3] = d;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_samples_done"}, 32'(exp_q.size()), 32'd0);
        check({name, "_txns_done"}, 32'(txn_q.size()), 32'd0);
    endtask

    task automatic cycles_to_cyc(output int n);
        n = 0;
        while (!wb_cyc_o && n < 60) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: bench did not finish");
        n_bad++;
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        // reset values
        #3 rst = 1'b0;
        #1;
        check("rst_ctl", {25'd0, wb_cyc_o, wb_stb_o, wb_we_o, smp_valid, smp_err, smp_last, busy}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'd0);
        check("rst_smp_data", smp_data, 32'd0);
        check("rst_smp_idx", 32'(smp_idx), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        load(32'h11, 32'h22, 32'h33, 32'h44);
        tick(1);
        rst = 1'b1;
        tick(1);

        // 1: plain sweep, enable-to-read latency, read+push rhythm
        period = 16'd10;
        exp_sweep(32'h11, 32'h22, 32'h33, 32'h44, -1, 1'b0);
        starts.delete();
        enable = 1'b1;
        cycles_to_cyc(n);
        check("t1_enable_to_rd", 32'(n), 32'd12);
        check("t1_first_adr", wb_adr_o, 32'h9900_0000);
        drain(200, "t1");
        enable = 1'b0;
        check("t1_rd_to_rd", (starts.size() >= 2) ? 32'(starts[1] - starts[0]) : 32'hFFFF_FFFF, 32'd3);
        check("t1_last_data", smp_data, 32'h44);
        check("t1_last_flag", 32'(smp_last), 32'd1);
        tick(5);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // 2: clear-on-read, then increments after the clear
        clear_on_read = 1'b1;
        load(32'd5, 32'd6, 32'd7, 32'd8);
        exp_sweep(32'd5, 32'd6, 32'd7, 32'd8, -1, 1'b1);
        enable = 1'b1;
        drain(400, "t2a");
        for (int k = 0; k < 4; k++) check("t2_cleared", mem[k], 32'd0);
        load(32'd1, 32'd2, 32'd3, 32'd4);
        exp_sweep(32'd1, 32'd2, 32'd3, 32'd4, -1, 1'b1);
        drain(400, "t2b");
        enable = 1'b0;
        tick(5);

        // 3: bus error on counter 2, no clear write for it
        load(32'h100, 32'h200, 32'h300, 32'h400);
        err_idx = 2;
        exp_sweep(32'h100, 32'h200, 32'h300, 32'h400, 2, 1'b1);
        enable = 1'b1;
        drain(400, "t3");
        enable = 1'b0;
        err_idx = -1;
        tick(5);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        check("t3_err_cnt_model", 32'(err_cnt), 32'(exp_err));
        check("t3_ctr2_not_cleared", mem[2], 32'h300);

        // 4: counter 1 never answers, watchdog aborts
        clear_on_read = 1'b0;
        load(32'hA, 32'hB, 32'hC, 32'hD);
        hang_idx = 1;
        lens.delete();
        exp_sweep(32'hA, 32'hB, 32'hC, 32'hD, 1, 1'b0);
        enable = 1'b1;
        drain(1000, "t4");
        enable = 1'b0;
        hang_idx = -1;
        tick(5);
        check("t4_len_ack", (lens.size() >= 2) ? 32'(lens[0]) : 32'hFFFF_FFFF, 32'd2);
        check("t4_len_timeout", (lens.size() >= 2) ? 32'(lens[1]) : 32'hFFFF_FFFF, 32'(TIMEOUT + 1));
        check("t4_err_cnt", 32'(err_cnt), 32'd2);

        // 5: back-pressure on the first sample
        load(32'hBEEF_0000, 32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003);
        smp_ready = 1'b0;
        exp_sweep(32'hBEEF_0000, 32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003, -1, 1'b0);
        enable = 1'b1;
        n = 0;
        while (!smp_valid && n < 100) begin
            tick(1);
            n++;
        end
        check("t5_valid_seen", 32'(smp_valid), 32'd1);
        tick(20);
        check("t5_valid_still", 32'(smp_valid), 32'd1);
        check("t5_data_still", smp_data, 32'hBEEF_0000);
        check("t5_busy", 32'(busy), 32'd1);
        smp_ready = 1'b1;
        drain(200, "t5");
        enable = 1'b0;
        tick(5);

        // 6: reset in the middle of a strobing read
        hang_idx = 0;
        exp_q.delete();
        txn_q.delete();
        txn_q.push_back('{adr: 32'h9900_0000, we: 1'b0});
        enable = 1'b1;
        n = 0;
        while (!wb_stb_o && n < 60) begin
            tick(1);
            n++;
        end
        check("t6_stb_seen", 32'(wb_stb_o), 32'd1);
        tick(3);
        #2 rst = 1'b0;
        #1;
        check("t6_async_cyc", 32'(wb_cyc_o), 32'd0);
        check("t6_async_stb", 32'(wb_stb_o), 32'd0);
        check("t6_async_valid", 32'(smp_valid), 32'd0);
        check("t6_async_err_cnt", 32'(err_cnt), 32'd0);
        hang_idx = -1;
        exp_q.delete();
        txn_q.delete();
        exp_err = 0;
        exp_sweep(32'hBEEF_0000, 32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003, -1, 1'b0);
        tick(2);
        rst = 1'b1;
        check("t6_busy_after_rst", 32'(busy), 32'd0);
        cycles_to_cyc(n);
        check("t6_restart_latency", 32'(n), 32'd12);
        drain(200, "t6");
        enable = 1'b0;
        tick(5);
        check("t6_err_cnt", 32'(err_cnt), 32'(exp_err));

        // 7: period 0 back-to-back sweeps, enable dropped mid-sweep
        period = 16'd0;
        load(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        exp_sweep(32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, 1'b0);
        exp_sweep(32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, 1'b0);
        starts.delete();
        hs.delete();
        enable = 1'b1;
        n = 0;
        while (exp_q.size() > 3 && n < 200) begin
            tick(1);
            n++;
        end
        enable = 1'b0;
        drain(200, "t7");
        check("t7_one_wait_cycle", (starts.size() >= 5 && hs.size() >= 4) ? 32'(starts[4] - hs[3]) : 32'hFFFF_FFFF, 32'd2);
        tick(20);
        check("t7_no_more_reads", 32'(starts.size()), 32'd8);
        check("t7_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
